control_unit: RTL
=================

# control_unit

Hardwired control sequencer for the Mini SRC CPU. It sits directly upstream of the datapath and drives that block's one-hot bus-source select, per-register load enables, ALU operation code, MDR read select and memory write strobe. It reads the IR value back from the datapath and steps through a fixed fetch/decode/execute sequence. A memory-ready handshake stretches the memory phases.

## Interface
Parameters:
- none; all encodings come from the shared package.

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- clr  in  1  reset, asynchronous and active-high; also forwarded unchanged to the datapath registers
- ir  in  32  IR contents fed back from the datapath
- mem_rdy  in  1  memory completes the current read or write in this cycle
- bus_sel  out  32  one-hot bus-source select (datapath encoder input)
- reg_enable  out  32  register load enables
- alu_sel  out  6  ALU operation code
- read  out  1  MDR input mux selects memory data
- write  out  1  memory write strobe
- run  out  1  high while the sequencer is not halted
- illegal  out  1  sticky flag: an illegal opcode was seen

## Operation
Index maps:
- bus_sel index 0-15: R0-R15; 16: HI; 17: LO; 18: Zhigh; 19: Zlow; 20: PC; 21: IR; 22: MDR; 23: MAR; 24: sign-extended C; 25-31 unused, held 0.
- reg_enable index 0-15: R0-R15; 16: HI; 17: LO; 18: Zhigh; 19: Zlow; 20: PC; 21: IR; 22: MDR; 23: MAR; 24: Y; 25-31 held 0.

IR fields:
- opcode = ir[31:27], Ra = ir[26:23], Rb = ir[22:19], Rc = ir[18:15].

Opcodes:
- ld 00000, st 00010, add 00011, sub 00100, and 00101, or 00110
- shr 00111, shra 01000, shl 01001, ror 01010, rol 01011
- addi 01100, andi 01101, ori 01110, mul 01111, div 10000, neg 10001, not 10010
- nop 11010, halt 11011; every other opcode is illegal.

ALU codes:
- ADD 0, SUB 1, AND 2, OR 3, SHR 4, SHRA 5, SHL 6, ROR 7, ROL 8, MUL 9, DIV 10, NEG 11, NOT 12, INC 13.

States: RESET, T0-T7, HALT. Fetch and per-class execute steps:
- T0: PC→bus, MARin, alu INC, Zlowin.
- T1: Zlow→bus, PCin, read=1. MDRin is asserted only in the cycle where mem_rdy=1; the sequencer stays in T1 until then.
- T2: MDR→bus, IRin.
- R-type ALU: T3 Rb→bus, Yin; T4 Rc→bus, op, Zlowin; T5 Zlow→bus, Rain; then T0.
- mul/div: T4 also enables Zhighin; T5 Zlow→bus, LOin; T6 Zhigh→bus, HIin; then T0.
- neg/not: T3 Rb→bus, op, Zlowin; T4 Zlow→bus, Rain; then T0.
- addi/andi/ori: like R-type, except T4 drives C onto the bus in place of Rc.
- ld: T3 Rb→bus, Yin; T4 C→bus, ADD, Zlowin; T5 Zlow→bus, MARin; T6 read=1, MDRin on mem_rdy, waits in T6; T7 MDR→bus, Rain.
- st: T3-T5 as ld; T6 Ra→bus, MDRin with read=0; T7 write=1, waits in T7 until mem_rdy.
- nop: T3→T0. halt: T3→HALT.
- HALT: absorbing until clr. run=0; all select, enable and strobe outputs are 0.
- Writes with Ra=0 are performed; R0 is not special.

## Timing
- Outputs are combinational from the current state and ir. They must settle within the cycle; the datapath captures on the rising edge that ends the state.
- In every state exactly one bus_sel bit is set, except RESET, HALT and the T7 write cycle, where bus_sel=0.
- clr asserted at any time: state goes to RESET immediately; bus_sel, reg_enable, alu_sel, read, write and illegal are all 0; run=1. The first edge after release enters T0.
- Latency with mem_rdy tied high: R-type, addi/andi/ori and neg/not take 6, 6 and 5 cycles; mul/div 7; ld/st 8; nop 4.
- Each low cycle of mem_rdy in T1/T6/T7 adds one cycle. mem_rdy is ignored in all other states.
- ir is sampled only in T3 and later; an IR load in T2 is visible in T3.

## Configuration
- ILLEGAL_TRAP_EN defined: an illegal opcode in T3 sets illegal and enters HALT.
- Not defined: an illegal opcode is executed as nop (T3→T0) and illegal remains 0.

## Structure
- Package cpu_pkg holds: opcode constants, ALU codes, bus_sel/reg_enable index constants, and the state enum. The datapath uses the same package.
- Sub-module control_decode: combinational ir→{class, alu op, Ra/Rb/Rc one-hot}, instantiated once.

## Test plan
- clr pulsed mid-T4 of an add → outputs 0 in the same cycle; T0 (PC bus_sel bit 20) on the first edge after release.
- IR=0x1A110000 (add R4,R2,R2), mem_rdy=1 → T4 alu_sel=0, reg_enable[19]=1; T5 bus_sel[19]=1, reg_enable[4]=1; 6 cycles total.
- mul (opcode 01111), mem_rdy=1 → T5 reg_enable[17]=1, T6 reg_enable[16]=1 with bus_sel[18]=1; 7 cycles.
- ld with mem_rdy low 3 cycles in T6 → T6 held 4 cycles; MDRin asserted with read=1 only in the last of them.
- st with mem_rdy=1 → T7 write=1, bus_sel=0, then T0.
- Opcode 11111 → with ILLEGAL_TRAP_EN: illegal=1, run=0 held until clr. Without it: returns to T0 after T3 and illegal stays 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared encodings for the Mini SRC CPU: opcodes, ALU operation codes,
// bus-source / register-enable bit positions, sequencer states and the
// instruction classes produced by the control decoder. The datapath uses
// the same package so both sides agree on every index.
// ---------------------------------------------------------------------------
package cpu_pkg;

   // Opcodes (ir[31:27])
   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_SHR  = 5'b00111;
   localparam logic [4:0] OP_SHRA = 5'b01000;
   localparam logic [4:0] OP_SHL  = 5'b01001;
   localparam logic [4:0] OP_ROR  = 5'b01010;
   localparam logic [4:0] OP_ROL  = 5'b01011;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   // ALU operation codes
   localparam logic [5:0] ALU_ADD  = 6'd0;
   localparam logic [5:0] ALU_SUB  = 6'd1;
   localparam logic [5:0] ALU_AND  = 6'd2;
   localparam logic [5:0] ALU_OR   = 6'd3;
   localparam logic [5:0] ALU_SHR  = 6'd4;
   localparam logic [5:0] ALU_SHRA = 6'd5;
   localparam logic [5:0] ALU_SHL  = 6'd6;
   localparam logic [5:0] ALU_ROR  = 6'd7;
   localparam logic [5:0] ALU_ROL  = 6'd8;
   localparam logic [5:0] ALU_MUL  = 6'd9;
   localparam logic [5:0] ALU_DIV  = 6'd10;
   localparam logic [5:0] ALU_NEG  = 6'd11;
   localparam logic [5:0] ALU_NOT  = 6'd12;
   localparam logic [5:0] ALU_INC  = 6'd13;

   // bus_sel bit positions (0-15 are R0-R15)
   localparam int SEL_HI  = 16;
   localparam int SEL_LO  = 17;
   localparam int SEL_ZHI = 18;
   localparam int SEL_ZLO = 19;
   localparam int SEL_PC  = 20;
   localparam int SEL_IR  = 21;
   localparam int SEL_MDR = 22;
   localparam int SEL_MAR = 23;
   localparam int SEL_C   = 24;

   // reg_enable bit positions (0-15 are R0-R15)
   localparam int EN_HI  = 16;
   localparam int EN_LO  = 17;
   localparam int EN_ZHI = 18;
   localparam int EN_ZLO = 19;
   localparam int EN_PC  = 20;
   localparam int EN_IR  = 21;
   localparam int EN_MDR = 22;
   localparam int EN_MAR = 23;
   localparam int EN_Y   = 24;

   typedef enum logic [3:0] {
      S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
   } state_t;

   // Execute-phase instruction classes
   typedef enum logic [3:0] {
      CL_RTYPE, CL_IMM, CL_MULDIV, CL_NEGNOT, CL_LD, CL_ST,
      CL_NOP, CL_HALT, CL_ILLEGAL
   } iclass_t;

   function automatic logic [15:0] onehot16(input logic [3:0] idx);
      return 16'h0001 << idx;
   endfunction

endpackage

// File: rtl/control_decode.sv
// ---------------------------------------------------------------------------
// control_decode
// Combinational IR decoder for the control sequencer.
// Ports:
//   ir      in  32  instruction register contents
//   iclass  out 4   execute class (iclass_t encoding)
//   alu_op  out 6   ALU code used by the class's compute step
//   ra_oh   out 16  one-hot of Ra (ir[26:23])
//   rb_oh   out 16  one-hot of Rb (ir[22:19])
//   rc_oh   out 16  one-hot of Rc (ir[18:15])
// ---------------------------------------------------------------------------
module control_decode
   import cpu_pkg::*;
(
   input  logic [31:0] ir,
   output logic [3:0]  iclass,
   output logic [5:0]  alu_op,
   output logic [15:0] ra_oh,
   output logic [15:0] rb_oh,
   output logic [15:0] rc_oh
);

   // Constant field is consumed by the datapath, not by the sequencer.
   logic unused_ir;
   assign unused_ir = ^ir[14:0];

   assign ra_oh = onehot16(ir[26:23]);
   assign rb_oh = onehot16(ir[22:19]);
   assign rc_oh = onehot16(ir[18:15]);

   always_comb begin
      iclass = CL_ILLEGAL;
      alu_op = ALU_ADD;
      case (ir[31:27])
         OP_LD:   begin iclass = CL_LD;     alu_op = ALU_ADD;  end
         OP_ST:   begin iclass = CL_ST;     alu_op = ALU_ADD;  end
         OP_ADD:  begin iclass = CL_RTYPE;  alu_op = ALU_ADD;  end
         OP_SUB:  begin iclass = CL_RTYPE;  alu_op = ALU_SUB;  end
         OP_AND:  begin iclass = CL_RTYPE;  alu_op = ALU_AND;  end
         OP_OR:   begin iclass = CL_RTYPE;  alu_op = ALU_OR;   end
         OP_SHR:  begin iclass = CL_RTYPE;  alu_op = ALU_SHR;  end
         OP_SHRA: begin iclass = CL_RTYPE;  alu_op = ALU_SHRA; end
         OP_SHL:  begin iclass = CL_RTYPE;  alu_op = ALU_SHL;  end
         OP_ROR:  begin iclass = CL_RTYPE;  alu_op = ALU_ROR;  end
         OP_ROL:  begin iclass = CL_RTYPE;  alu_op = ALU_ROL;  end
         OP_ADDI: begin iclass = CL_IMM;    alu_op = ALU_ADD;  end
         OP_ANDI: begin iclass = CL_IMM;    alu_op = ALU_AND;  end
         OP_ORI:  begin iclass = CL_IMM;    alu_op = ALU_OR;   end
         OP_MUL:  begin iclass = CL_MULDIV; alu_op = ALU_MUL;  end
         OP_DIV:  begin iclass = CL_MULDIV; alu_op = ALU_DIV;  end
         OP_NEG:  begin iclass = CL_NEGNOT; alu_op = ALU_NEG;  end
         OP_NOT:  begin iclass = CL_NEGNOT; alu_op = ALU_NOT;  end
         OP_NOP:  iclass = CL_NOP;
         OP_HALT: iclass = CL_HALT;
         default: iclass = CL_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
// Hardwired fetch/decode/execute sequencer for the Mini SRC CPU.
// Build option: ILLEGAL_TRAP_EN -- when defined, an illegal opcode sets the
// sticky illegal flag and halts; otherwise it is executed as a nop.
// Ports:
//   clk        in  1   system clock
//   clr        in  1   async active-high reset (also drives datapath regs)
//   ir         in  32  IR contents fed back from the datapath
//   mem_rdy    in  1   memory completes the current access this cycle
//   bus_sel    out 32  one-hot bus-source select
//   reg_enable out 32  register load enables
//   alu_sel    out 6   ALU operation code
//   read       out 1   MDR input mux selects memory data
//   write      out 1   memory write strobe
//   run        out 1   high unless halted
//   illegal    out 1   sticky illegal-opcode flag
// Outputs are combinational from the current state and ir.
// ---------------------------------------------------------------------------
module control_unit
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] ir,
   input  logic        mem_rdy,
   output logic [31:0] bus_sel,
   output logic [31:0] reg_enable,
   output logic [5:0]  alu_sel,
   output logic        read,
   output logic        write,
   output logic        run,
   output logic        illegal
);

   state_t      state;
   logic        illegal_q;
   logic [3:0]  cls_raw;
   iclass_t     cls;
   logic [5:0]  dec_alu;
   logic [15:0] ra_oh;
   logic [15:0] rb_oh;
   logic [15:0] rc_oh;

   control_decode u_dec (
      .ir     (ir),
      .iclass (cls_raw),
      .alu_op (dec_alu),
      .ra_oh  (ra_oh),
      .rb_oh  (rb_oh),
      .rc_oh  (rc_oh)
   );

   assign cls = iclass_t'(cls_raw);

   // Sequencing. ir (via cls) is only consulted from T3 onward; the IR
   // load happens at the end of T2.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state     <= S_RESET;
         illegal_q <= 1'b0;
      end else begin
         case (state)
            S_RESET: state <= S_T0;
            S_T0:    state <= S_T1;
            S_T1:    if (mem_rdy) state <= S_T2;
            S_T2:    state <= S_T3;
            S_T3: begin
               case (cls)
                  CL_NOP:  state <= S_T0;
                  CL_HALT: state <= S_HALT;
                  CL_ILLEGAL: begin
`ifdef ILLEGAL_TRAP_EN
                     state     <= S_HALT;
                     illegal_q <= 1'b1;
`else
                     state     <= S_T0;
`endif
                  end
                  default: state <= S_T4;
               endcase
            end
            S_T4:    state <= (cls == CL_NEGNOT) ? S_T0 : S_T5;
            S_T5:    state <= (cls == CL_RTYPE || cls == CL_IMM) ? S_T0 : S_T6;
            S_T6: begin
               case (cls)
                  CL_LD:   if (mem_rdy) state <= S_T7;
                  CL_ST:   state <= S_T7;
                  default: state <= S_T0;
               endcase
            end
            S_T7: begin
               // Store holds its write strobe until memory accepts it.
               if (cls != CL_ST || mem_rdy) state <= S_T0;
            end
            S_HALT:  state <= S_HALT;
            default: state <= S_RESET;
         endcase
      end
   end

   assign run     = (state != S_HALT);
   assign illegal = illegal_q;

   // Control word decode. Steps whose bus value is irrelevant (T3 of
   // nop/halt, T6 of ld) still drive a single source so the datapath
   // encoder always sees a legal one-hot.
   always_comb begin
      bus_sel    = '0;
      reg_enable = '0;
      alu_sel    = ALU_ADD;
      read       = 1'b0;
      write      = 1'b0;
      case (state)
         S_T0: begin
            bus_sel[SEL_PC]    = 1'b1;
            reg_enable[EN_MAR] = 1'b1;
            reg_enable[EN_ZLO] = 1'b1;
            alu_sel            = ALU_INC;
         end
         S_T1: begin
            bus_sel[SEL_ZLO]   = 1'b1;
            reg_enable[EN_PC]  = 1'b1;
            reg_enable[EN_MDR] = mem_rdy;
            read               = 1'b1;
         end
         S_T2: begin
            bus_sel[SEL_MDR]  = 1'b1;
            reg_enable[EN_IR] = 1'b1;
         end
         S_T3: begin
            bus_sel[15:0] = rb_oh;
            case (cls)
               CL_RTYPE, CL_IMM, CL_MULDIV, CL_LD, CL_ST:
                  reg_enable[EN_Y] = 1'b1;
               CL_NEGNOT: begin
                  reg_enable[EN_ZLO] = 1'b1;
                  alu_sel            = dec_alu;
               end
               default: ;
            endcase
         end
         S_T4: begin
            case (cls)
               CL_RTYPE: begin
                  bus_sel[15:0]      = rc_oh;
                  reg_enable[EN_ZLO] = 1'b1;
                  alu_sel            = dec_alu;
               end
               CL_IMM: begin
                  bus_sel[SEL_C]     = 1'b1;
                  reg_enable[EN_ZLO] = 1'b1;
                  alu_sel            = dec_alu;
               end
               CL_MULDIV: begin
                  bus_sel[15:0]      = rc_oh;
                  reg_enable[EN_ZLO] = 1'b1;
                  reg_enable[EN_ZHI] = 1'b1;
                  alu_sel            = dec_alu;
               end
               CL_NEGNOT: begin
                  bus_sel[SEL_ZLO]  = 1'b1;
                  reg_enable[15:0]  = ra_oh;
               end
               CL_LD, CL_ST: begin
                  // Effective address = Rb + C
                  bus_sel[SEL_C]     = 1'b1;
                  reg_enable[EN_ZLO] = 1'b1;
                  alu_sel            = ALU_ADD;
               end
               default: bus_sel[SEL_ZLO] = 1'b1;
            endcase
         end
         S_T5: begin
            bus_sel[SEL_ZLO] = 1'b1;
            case (cls)
               CL_RTYPE, CL_IMM: reg_enable[15:0]  = ra_oh;
               CL_MULDIV:        reg_enable[EN_LO] = 1'b1;
               CL_LD, CL_ST:     reg_enable[EN_MAR] = 1'b1;
               default: ;
            endcase
         end
         S_T6: begin
            case (cls)
               CL_MULDIV: begin
                  bus_sel[SEL_ZHI]  = 1'b1;
                  reg_enable[EN_HI] = 1'b1;
               end
               CL_LD: begin
                  bus_sel[SEL_MDR]   = 1'b1;
                  reg_enable[EN_MDR] = mem_rdy;
                  read               = 1'b1;
               end
               CL_ST: begin
                  bus_sel[15:0]      = ra_oh;
                  reg_enable[EN_MDR] = 1'b1;
               end
               default: bus_sel[SEL_ZLO] = 1'b1;
            endcase
         end
         S_T7: begin
            case (cls)
               CL_LD: begin
                  bus_sel[SEL_MDR] = 1'b1;
                  reg_enable[15:0] = ra_oh;
               end
               CL_ST:   write = 1'b1;
               default: bus_sel[SEL_MDR] = 1'b1;
            endcase
         end
         default: ;
      endcase
   end

endmodule
